pong_match_controller: RTL and testbench
========================================

# pong_match_controller

Match sequencer for the pong game datapath. It owns the game-step cadence, issues serve/recentre commands to the ball engine, consumes the engine's miss flags, keeps both scores, and declares a winner. The ball and paddle engine advances only on `engine_step` and reloads its serve position only on `engine_load`. The block sits between the top-level input pins and that engine.

## Interface
- `TICK_DIV`, default 4: clock cycles per game step. Must be ≥ 2.
- `SERVE_WAIT`, default 8: game steps the ball is held before play starts. Must be ≥ 1.
- `WIN_SCORE`, default 7: points needed to win. Must be in 1..2^SCORE_W−1.
- `SCORE_W`, default 4: score counter width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset; overrides every other input.
- `start`  in  1  level; sampled in IDLE and GAMEOVER only.
- `pause`  in  1  level; freezes the step divider and serve counter.
- `miss_left`  in  1  engine flag: ball passed the left edge (right player scores).
- `miss_right`  in  1  engine flag: ball passed the right edge (left player scores).
- `engine_step`  out  1  one-cycle strobe: advance the datapath one game step.
- `engine_load`  out  1  one-cycle strobe: recentre the ball and load `serve_dir`.
- `serve_dir`  out  1  0 = serve toward left, 1 = serve toward right. Valid whenever `engine_load`=1.
- `score_left`  out  SCORE_W  left player score.
- `score_right`  out  SCORE_W  right player score.
- `game_over`  out  1  high while in GAMEOVER.
- `winner`  out  1  0 = left, 1 = right. Meaningful only when `game_over`=1.
- `state`  out  3  current state: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4.

## Operation
- **Reset** (takes priority over all other inputs):
  - state=IDLE; scores=0; divider=0; serve counter=0.
  - `serve_dir`=1; `winner`=0; `game_over`=0; `engine_step`=0; `engine_load`=0.
- **Divider**: counts 0..TICK_DIV−1 and wraps.
  - Advances only in SERVE or PLAY with `pause`=0.
  - Holds when `pause`=1. Forced to 0 in IDLE, POINT and GAMEOVER, and on every state change.
  - tick = (divider==TICK_DIV−1) and `pause`=0.
- **IDLE**: when `start`=1, go to SERVE with `serve_dir`=1.
- **GAMEOVER**: when `start`=1, clear both scores and go to SERVE with `serve_dir`=1.
- **SERVE**:
  - `engine_load`=1 during the first SERVE cycle only.
  - Each tick increments the serve counter. The tick that occurs when the counter equals SERVE_WAIT−1 moves the FSM to PLAY and clears the counter.
  - No `engine_step` is issued in SERVE.
- **PLAY**:
  - `engine_step` = tick.
  - Miss flags are honoured every PLAY cycle, including while paused. Any miss moves the FSM to POINT; the score update is registered on that same edge:
    - `miss_left` only: `score_right`+1, `serve_dir`=0.
    - `miss_right` only: `score_left`+1, `serve_dir`=1.
    - Both flags set: no score change, `serve_dir` unchanged.
  - Miss flags are ignored in every state except PLAY.
- **POINT**: lasts exactly one cycle.
  - If `score_left`==WIN_SCORE: go to GAMEOVER with `winner`=0.
  - Else if `score_right`==WIN_SCORE: go to GAMEOVER with `winner`=1.
  - Otherwise go to SERVE.
  - A score can increase only while it is below WIN_SCORE, so neither score ever exceeds WIN_SCORE and the counters cannot wrap.
- **Unused state codes** 5–7: return to IDLE on the next clock with scores cleared.

## Timing
- `state`, scores, `serve_dir`, `winner` and `game_over` are registered.
- `engine_step` and `engine_load` are decoded from registered state and divider only; the sole exception is that `engine_step` is gated by `pause`. They never depend on `start` or the miss flags.
- **IDLE → SERVE**: `start` sampled high at edge N gives state=SERVE and `engine_load`=1 during cycle N+1.
- **Serve duration**: SERVE lasts TICK_DIV·SERVE_WAIT unpaused cycles (32 with defaults). Pause cycles add to this 1:1.
- **First step**: the first `engine_step` occurs in the TICK_DIV-th cycle of PLAY. It is never in the PLAY entry cycle.
- **Step spacing**: consecutive steps are exactly TICK_DIV cycles apart while unpaused. After a pause, the divider resumes from its frozen value, so step phase is preserved.
- **Miss to re-serve**: a miss sampled at edge M gives POINT in cycle M+1, then SERVE (with `engine_load`) in cycle M+2. The engine must hold the miss flag ≥1 cycle; a flag held longer is not re-counted because the FSM has left PLAY.
- **Reset mid-operation**: the next cycle shows the reset values regardless of `start`/`pause`/miss. `start` still high on the following edge begins a new match.

## Test plan
- **Match start and cadence**: reset 2 cycles, then `start`=1 for 1 cycle (defaults).
  - `engine_load`=1 in exactly one cycle.
  - state=PLAY 32 cycles later.
  - First `engine_step` 3 cycles after PLAY entry, then every 4 cycles.
  - Scores 0/0.
- **Left miss**: in PLAY, `miss_left` pulsed for 1 cycle.
  - `score_right`=1 and state=POINT in the next cycle.
  - SERVE one cycle after that, with `engine_load`=1 and `serve_dir`=0.
  - No `engine_step` until PLAY resumes.
- **Simultaneous miss**: `miss_left`=`miss_right`=1 in PLAY.
  - Scores unchanged; POINT then SERVE; `serve_dir` keeps its prior value.
- **Pause**: `pause`=1 for 10 cycles mid-PLAY, starting with divider=1.
  - No `engine_step` during the pause.
  - Next step is 2 cycles after `pause` falls.
  - Pause during SERVE extends SERVE by exactly 10 cycles.
- **Game over**: drive 7 `miss_right` events.
  - After the 7th: `score_left`=7, GAMEOVER, `game_over`=1, `winner`=0.
  - Further misses and steps are ignored.
  - `start`=1 then gives scores 0/0, SERVE, `serve_dir`=1, `engine_load` pulse.
- **Reset priority**: assert `reset` in PLAY with `start`=1 and `miss_left`=1 held.
  - Next cycle: IDLE, scores 0, no strobes.
  - Release `reset` with `start` still high: SERVE one cycle later.

Source files
------------

// File: rtl/pong_match_controller.sv
// pong_match_controller
//   Match sequencer for the pong datapath: generates the game-step cadence,
//   issues serve (engine_load) and step (engine_step) strobes to the ball
//   engine, consumes its miss flags, keeps both scores and declares a winner.
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   synchronous active-high reset, overrides everything
//   start        in   begin a match (sampled in IDLE and GAMEOVER)
//   pause        in   freezes step divider and serve counter
//   miss_left    in   ball passed left edge  -> right player scores
//   miss_right   in   ball passed right edge -> left player scores
//   engine_step  out  one-cycle strobe: advance the engine one game step
//   engine_load  out  one-cycle strobe: recentre ball, load serve_dir
//   serve_dir    out  0 = serve toward left, 1 = toward right
//   score_left   out  left player score
//   score_right  out  right player score
//   game_over    out  high while in GAMEOVER
//   winner       out  0 = left, 1 = right (valid with game_over)
//   state        out  IDLE=0 SERVE=1 PLAY=2 POINT=3 GAMEOVER=4
module pong_match_controller #(
  parameter int TICK_DIV   = 4,
  parameter int SERVE_WAIT = 8,
  parameter int WIN_SCORE  = 7,
  parameter int SCORE_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               engine_step,
  output logic               engine_load,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = (SERVE_WAIT > 1) ? $clog2(SERVE_WAIT) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SERVE_WAIT - 1);
  localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    PLAY     = 3'd2,
    POINT    = 3'd3,
    GAMEOVER = 3'd4
  } state_t;

  state_t             r_state;
  logic [DIV_W-1:0]   r_div;
  logic [CNT_W-1:0]   r_cnt;
  logic [SCORE_W-1:0] r_score_left;
  logic [SCORE_W-1:0] r_score_right;
  logic               r_serve_dir;
  logic               r_winner;
  logic               r_game_over;
  logic               r_load;
  logic               w_tick;

  // The divider only moves in SERVE/PLAY, so outside them it sits at 0 and
  // w_tick stays low unless TICK_DIV would be 1 (disallowed).
  assign w_tick      = (r_div == DIV_LAST) && !pause;
  assign engine_step = (r_state == PLAY) && w_tick;
  // r_load is raised on the edge that enters SERVE, so it marks exactly the
  // first SERVE cycle even if pause is held at that time.
  assign engine_load = r_load;
  assign serve_dir   = r_serve_dir;
  assign score_left  = r_score_left;
  assign score_right = r_score_right;
  assign game_over   = r_game_over;
  assign winner      = r_winner;
  assign state       = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_div         <= '0;
      r_cnt         <= '0;
      r_score_left  <= '0;
      r_score_right <= '0;
      r_serve_dir   <= 1'b1;
      r_winner      <= 1'b0;
      r_game_over   <= 1'b0;
      r_load        <= 1'b0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        IDLE: begin
          r_div <= '0;
          r_cnt <= '0;
          if (start) begin
            r_state     <= SERVE;
            r_serve_dir <= 1'b1;
            r_load      <= 1'b1;
          end
        end

        SERVE: begin
          if (w_tick) begin
            r_div <= '0;
            if (r_cnt == CNT_LAST) begin
              r_state <= PLAY;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else if (!pause) begin
            r_div <= r_div + DIV_W'(1);
          end
        end

        PLAY: begin
          // Misses win over a coincident tick; the step strobe for that
          // cycle is still issued since it is decoded from state/divider.
          if (miss_left || miss_right) begin
            r_state <= POINT;
            r_div   <= '0;
            if (miss_left && !miss_right) begin
              if (r_score_right < SCORE_WIN)
                r_score_right <= r_score_right + SCORE_W'(1);
              r_serve_dir <= 1'b0;
            end else if (miss_right && !miss_left) begin
              if (r_score_left < SCORE_WIN)
                r_score_left <= r_score_left + SCORE_W'(1);
              r_serve_dir <= 1'b1;
            end
          end else if (w_tick) begin
            r_div <= '0;
          end else if (!pause) begin
            r_div <= r_div + DIV_W'(1);
          end
        end

        POINT: begin
          r_div <= '0;
          r_cnt <= '0;
          if (r_score_left == SCORE_WIN) begin
            r_state     <= GAMEOVER;
            r_winner    <= 1'b0;
            r_game_over <= 1'b1;
          end else if (r_score_right == SCORE_WIN) begin
            r_state     <= GAMEOVER;
            r_winner    <= 1'b1;
            r_game_over <= 1'b1;
          end else begin
            r_state <= SERVE;
            r_load  <= 1'b1;
          end
        end

        GAMEOVER: begin
          r_div <= '0;
          r_cnt <= '0;
          if (start) begin
            r_state       <= SERVE;
            r_score_left  <= '0;
            r_score_right <= '0;
            r_serve_dir   <= 1'b1;
            r_game_over   <= 1'b0;
            r_load        <= 1'b1;
          end
        end

        default: begin
          r_state       <= IDLE;
          r_div         <= '0;
          r_cnt         <= '0;
          r_score_left  <= '0;
          r_score_right <= '0;
          r_game_over   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_match_controller.sv
module tb_pong_match_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic       engine_step;
  logic       engine_load;
  logic       serve_dir;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       game_over;
  logic       winner;
  logic [2:0] state;

  int n_total = 0;
  int n_bad   = 0;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;

  pong_match_controller dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .miss_left   (miss_left),
    .miss_right  (miss_right),
    .engine_step (engine_step),
    .engine_load (engine_load),
    .serve_dir   (serve_dir),
    .score_left  (score_left),
    .score_right (score_right),
    .game_over   (game_over),
    .winner      (winner),
    .state       (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, st, ps, ml, mr;
    logic [2:0] e_state;
    logic       e_step, e_load, e_dir, e_go;
    logic [3:0] e_sl, e_sr;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: inputs applied just after the rising edge, outputs sampled
  // shortly after, well before the next edge.
  task automatic drive(input logic r, input logic s, input logic p,
                       input logic l, input logic m);
    @(posedge clk);
    #1;
    reset = r; start = s; pause = p; miss_left = l; miss_right = m;
    #1;
  endtask

  task automatic wait_play();
    bit found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      drive(0, 0, 0, 0, 0);
      if (state == 3'(S_PLAY)) found = 1;
    end
    chk("wait_play", int'(found), 1);
  endtask

  vec_t vecs[6];

  initial begin
    //        rst st ps ml mr  state    step load dir go sl sr
    vecs[0] = '{1, 0, 0, 0, 0, S_IDLE,  0, 0, 1, 0, 0, 0};
    vecs[1] = '{1, 1, 0, 1, 0, S_IDLE,  0, 0, 1, 0, 0, 0};
    vecs[2] = '{0, 0, 0, 1, 1, S_IDLE,  0, 0, 1, 0, 0, 0};
    vecs[3] = '{0, 1, 0, 0, 0, S_IDLE,  0, 0, 1, 0, 0, 0};
    vecs[4] = '{0, 0, 0, 0, 0, S_SERVE, 0, 1, 1, 0, 0, 0};
    vecs[5] = '{0, 1, 0, 0, 0, S_SERVE, 0, 0, 1, 0, 0, 0};

    for (int v = 0; v < 6; v++) begin
      drive(vecs[v].rst, vecs[v].st, vecs[v].ps, vecs[v].ml, vecs[v].mr);
      chk($sformatf("v%0d_state", v), state, vecs[v].e_state);
      chk($sformatf("v%0d_step", v), engine_step, vecs[v].e_step);
      chk($sformatf("v%0d_load", v), engine_load, vecs[v].e_load);
      chk($sformatf("v%0d_dir", v), serve_dir, vecs[v].e_dir);
      chk($sformatf("v%0d_go", v), game_over, vecs[v].e_go);
      chk($sformatf("v%0d_sl", v), score_left, vecs[v].e_sl);
      chk($sformatf("v%0d_sr", v), score_right, vecs[v].e_sr);
      $display("vector %0d: state=%0d step=%0d load=%0d dir=%0d sl=%0d sr=%0d",
               v, state, engine_step, engine_load, serve_dir, score_left, score_right);
    end

    // Remaining SERVE cycles 3..32 of the first serve.
    for (int c = 3; c <= 32; c++) begin
      drive(0, 0, 0, 0, 0);
      chk("serve_hold", state, S_SERVE);
      chk("serve_nostep", engine_step, 0);
      chk("serve_noload", engine_load, 0);
    end
    drive(0, 0, 0, 0, 0);
    chk("play_entry", state, S_PLAY);
    chk("play_entry_step", engine_step, 0);
    $display("cadence: PLAY reached 32 cycles after load");

    // PLAY cycles 2..9: steps land on cycles 4 and 8.
    for (int c = 2; c <= 9; c++) begin
      drive(0, 0, 0, 0, 0);
      chk($sformatf("cadence_c%0d", c), engine_step, int'(c % 4 == 0));
    end
    chk("scores_l_start", score_left, 0);
    chk("scores_r_start", score_right, 0);

    // Pause 10 cycles starting with divider at 1.
    for (int c = 10; c <= 19; c++) begin
      drive(0, 0, 1, 0, 0);
      chk("pause_nostep", engine_step, 0);
      chk("pause_state", state, S_PLAY);
    end
    drive(0, 0, 0, 0, 0); chk("resume_c20", engine_step, 0);
    drive(0, 0, 0, 0, 0); chk("resume_c21", engine_step, 0);
    drive(0, 0, 0, 0, 0); chk("resume_c22", engine_step, 1);
    $display("pause: step phase preserved");

    // Left miss.
    drive(0, 0, 0, 1, 0); chk("lmiss_play", state, S_PLAY);
    drive(0, 0, 0, 0, 0);
    chk("lmiss_point", state, S_POINT);
    chk("lmiss_sr", score_right, 1);
    chk("lmiss_sl", score_left, 0);
    chk("lmiss_point_step", engine_step, 0);
    drive(0, 0, 0, 0, 0);
    chk("lmiss_serve", state, S_SERVE);
    chk("lmiss_load", engine_load, 1);
    chk("lmiss_dir", serve_dir, 0);
    $display("left miss: score %0d/%0d dir=%0d", score_left, score_right, serve_dir);

    // Serve with 10 pause cycles: SERVE lasts 42 cycles; a miss in SERVE is ignored.
    for (int c = 2; c <= 42; c++) begin
      drive(0, 0, (c >= 5 && c <= 14), 0, (c == 20));
      chk("pserve_state", state, S_SERVE);
      chk("pserve_step", engine_step, 0);
      chk("pserve_load", engine_load, 0);
      chk("pserve_sl", score_left, 0);
    end
    // Simultaneous miss in the PLAY entry cycle.
    drive(0, 0, 0, 1, 1); chk("pserve_play", state, S_PLAY);
    drive(0, 0, 0, 0, 0);
    chk("both_point", state, S_POINT);
    chk("both_sl", score_left, 0);
    chk("both_sr", score_right, 1);
    drive(0, 0, 0, 0, 0);
    chk("both_serve", state, S_SERVE);
    chk("both_load", engine_load, 1);
    chk("both_dir", serve_dir, 0);
    $display("simultaneous miss: score %0d/%0d dir=%0d", score_left, score_right, serve_dir);

    // Seven right misses -> left wins.
    for (int k = 1; k <= 7; k++) begin
      wait_play();
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0);
      chk("rmiss_point", state, S_POINT);
      chk("rmiss_sl", score_left, k);
      chk("rmiss_sr", score_right, 1);
      drive(0, 0, 0, 0, 0);
      if (k < 7) begin
        chk("rmiss_serve", state, S_SERVE);
        chk("rmiss_load", engine_load, 1);
        chk("rmiss_dir", serve_dir, 1);
      end else begin
        chk("over_state", state, S_OVER);
        chk("over_go", game_over, 1);
        chk("over_winner", winner, 0);
        chk("over_load", engine_load, 0);
      end
      $display("point %0d: score %0d/%0d state=%0d", k, score_left, score_right, state);
    end

    for (int i = 0; i < 5; i++) begin
      drive(0, 0, i[0], 1, (i != 2));
      chk("over_hold", state, S_OVER);
      chk("over_hold_sl", score_left, 7);
      chk("over_hold_sr", score_right, 1);
      chk("over_hold_step", engine_step, 0);
    end
    drive(0, 1, 0, 0, 0); chk("over_start_cycle", state, S_OVER);
    drive(0, 0, 0, 0, 0);
    chk("restart_state", state, S_SERVE);
    chk("restart_sl", score_left, 0);
    chk("restart_sr", score_right, 0);
    chk("restart_dir", serve_dir, 1);
    chk("restart_load", engine_load, 1);
    chk("restart_go", game_over, 0);
    $display("restart: score %0d/%0d", score_left, score_right);

    // Score a point, then reset in PLAY with start and miss_left held.
    wait_play();
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    chk("pre_reset_sr", score_right, 1);
    wait_play();
    drive(1, 1, 0, 1, 0); chk("rst_play", state, S_PLAY);
    drive(0, 1, 0, 1, 0);
    chk("rst_state", state, S_IDLE);
    chk("rst_sl", score_left, 0);
    chk("rst_sr", score_right, 0);
    chk("rst_step", engine_step, 0);
    chk("rst_load", engine_load, 0);
    chk("rst_dir", serve_dir, 1);
    chk("rst_go", game_over, 0);
    drive(0, 0, 0, 0, 0);
    chk("rst_serve", state, S_SERVE);
    chk("rst_serve_load", engine_load, 1);
    $display("reset priority: state=%0d load=%0d", state, engine_load);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
